// File: rtl/serial_subtractor_if.sv
// Request/result bundle for the bit-serial subtractor.
// The overflow signal exists only when SERIAL_SUBTRACTOR_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             diff_bit;
    logic             diff_bit_valid;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             overflow;
`endif

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out, diff_bit, diff_bit_valid
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        , input overflow
`endif
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out, diff_bit, diff_bit_valid
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        , output overflow
`endif
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B: one full-subtractor cell, LSB first, WIDTH+1 cycles start-to-done.
// Optional signed overflow output enabled by SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, diff_r;
    logic [CW-1:0]    cnt;
    logic             brw, borrow_r;
    logic             d, bout, last;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             ovf_r;
`endif

    // Full-subtractor cell on the current operand LSBs
    assign d    = a_sh[0] ^ b_sh[0] ^ brw;
    assign bout = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw);
    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt          = state;
        bus.busy           = 1'b0;
        bus.done           = 1'b0;
        bus.diff_bit       = 1'b0;
        bus.diff_bit_valid = 1'b0;
        case (state)
            IDLE: if (bus.start) state_nxt = RUN;
            RUN: begin
                bus.busy           = 1'b1;
                bus.diff_bit       = d;
                bus.diff_bit_valid = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            diff_r   <= '0;
            cnt      <= '0;
            brw      <= 1'b0;
            borrow_r <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_r    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    a_sh     <= bus.a;
                    b_sh     <= bus.b;
                    diff_r   <= '0;
                    cnt      <= '0;
                    brw      <= 1'b0;
                    borrow_r <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    ovf_r    <= 1'b0;
`endif
                end
                RUN: begin
                    diff_r <= {d, diff_r[WIDTH-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    brw    <= bout;
                    cnt    <= cnt + 1'b1;
                    // On the last step the LSBs are the original operand MSBs
                    if (last) begin
                        borrow_r <= bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        ovf_r    <= (a_sh[0] != b_sh[0]) && (d != a_sh[0]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.diff       = diff_r;
    assign bus.borrow_out = borrow_r;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign bus.overflow   = ovf_r;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor (WIDTH=8); inputs driven and outputs sampled on negedge.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) sif ();
    serial_subtractor #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(sif));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Starts one operation from IDLE; optionally pulses a competing start in RUN cycle 3.
    task automatic op(input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] ed, input logic eb, input bit pulse3);
        logic [7:0] bits;
        int ndone;
        bits = '0;
        ndone = 0;
        sif.start = 1'b1; sif.a = av; sif.b = bv;
        @(negedge clk);
        sif.start = 1'b0; sif.a = ~av; sif.b = ~bv;
        chk("diff_clr", sif.diff, 0);
        chk("borrow_clr", sif.borrow_out, 0);
        for (int i = 0; i < 8; i++) begin
            chk("busy", sif.busy, 1);
            chk("bit_valid", sif.diff_bit_valid, 1);
            bits[i] = sif.diff_bit;
            if (sif.done) ndone++;
            if (pulse3 && i == 3) begin sif.start = 1'b1; sif.a = 8'h3C; sif.b = 8'h5A; end
            if (pulse3 && i == 4) sif.start = 1'b0;
            @(negedge clk);
        end
        if (sif.done) ndone++;
        chk("done", sif.done, 1);
        chk("busy_done", sif.busy, 0);
        chk("diff", sif.diff, ed);
        chk("borrow", sif.borrow_out, eb);
        chk("bit_seq", bits, ed);
        @(negedge clk);
        if (sif.done) ndone++;
        chk("done_once", ndone, 1);
        chk("idle_busy", sif.busy, 0);
        chk("idle_valid", sif.diff_bit_valid, 0);
    endtask

    initial begin
        sif.start = 1'b0; sif.a = '0; sif.b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", sif.busy, 0);
        chk("rst_done", sif.done, 0);
        chk("rst_diff", sif.diff, 0);
        chk("rst_borrow", sif.borrow_out, 0);
        chk("rst_valid", sif.diff_bit_valid, 0);
        rst = 1'b0;
        @(negedge clk);

        op(8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0);
        op(8'h3C, 8'h5A, 8'hE2, 1'b1, 1'b0);
        op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);

        // Competing start mid-run is ignored; result then holds while idle
        op(8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_diff", sif.diff, 8'h1E);
            chk("hold_done", sif.done, 0);
        end

        // Reset in RUN cycle 4 abandons the operation
        sif.start = 1'b1; sif.a = 8'h3C; sif.b = 8'h5A;
        @(negedge clk);
        sif.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_busy", sif.busy, 0);
        chk("mr_done", sif.done, 0);
        chk("mr_diff", sif.diff, 0);
        chk("mr_borrow", sif.borrow_out, 0);
        chk("mr_bit", sif.diff_bit, 0);
        chk("mr_valid", sif.diff_bit_valid, 0);
        begin
            int nd;
            nd = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (sif.done) nd++;
            end
            chk("mr_no_done", nd, 0);
        end
        op(8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0);

        // start held high: new op every WIDTH+2 cycles
        sif.start = 1'b1; sif.a = 8'h10; sif.b = 8'h01;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            chk("bb_done", sif.done, (j % 10 == 8) ? 1 : 0);
            if (j % 10 == 8) chk("bb_diff", sif.diff, 8'h0F);
        end
        sif.start = 1'b0;
        repeat (2) @(negedge clk);

`ifdef SERIAL_SUBTRACTOR_OVF_EN
        op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b0);
        chk("ovf_set", sif.overflow, 1);
        op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        chk("ovf_clr", sif.overflow, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
